dpi_stream_sequencer: RTL and testbench
=======================================

Name: dpi_stream_sequencer

Overview:
- Front end of the per-stream regex finger array: accepts raw packet bytes, pulls a flow key from each packet's leading bytes, and resolves it to a stream ID through a small fully-associative flow table.
- Drives each finger wrapper's restore/stream/finalize sequence: load_state pulse, payload bytes, eop pulse.
- Guarantees the restore-to-first-char and last-char-to-eop spacing the fingers need. Fans out to every finger in parallel.

Parameters:
- NUM_STREAMS, 64, flow-table entries; must equal 2**SID_W.
- SID_W, 6, stream ID width.
- KEY_BYTES, 4, leading packet bytes forming the flow key; these bytes are not forwarded as chars.
- EOP_GAP, 2, idle cycles between the last char_in_vld and eop; minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_data  in  8  input byte
- s_valid  in  1  input byte valid
- s_sop  in  1  first byte of packet, qualified by s_valid
- s_eop  in  1  last byte of packet, qualified by s_valid
- s_ready  out  1  byte accepted when s_valid & s_ready
- flush  in  1  clear flow table; level, sampled in IDLE only
- char_in  out  8  payload byte to fingers
- char_in_vld  out  1  char_in valid
- load_state  out  1  one-cycle restore pulse
- stream_id  out  SID_W  resolved stream; stable from load_state through eop
- new_stream_id  out  1  flow was a table miss; stable with stream_id
- eop  out  1  one-cycle finalize pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state IDLE; all outputs 0 except s_ready=1.
  - All table valid bits 0; alloc_ptr 0; key register 0.
- FSM states: IDLE, KEY, LOOKUP, LOAD, WAIT, STREAM, DRAIN, FIN.
- IDLE:
  - s_ready=1. A beat with s_sop is byte 0 of the key; go to KEY, or to LOOKUP if s_eop is also set or KEY_BYTES=1.
  - Beats without s_sop are dropped.
  - If flush=1: clear all valid bits, alloc_ptr<=0, stay in IDLE; a sop beat in that cycle is dropped.
- KEY:
  - s_ready=1. Byte i goes to key[8*(KEY_BYTES-i)-1 -: 8], first byte most significant.
  - After byte KEY_BYTES-1, or on s_eop, go to LOOKUP.
  - s_eop before a full key: zero-pad the key and set short flag.
  - s_sop in KEY is treated as ordinary data.
- LOOKUP (1 cycle, s_ready=0):
  - Compare key against all valid entries.
  - Hit: stream_id <= lowest matching index; new_stream_id <= 0.
  - Miss: stream_id <= alloc_ptr; new_stream_id <= 1; write key and set valid at alloc_ptr; alloc_ptr <= alloc_ptr+1, wrapping 63 -> 0.
  - On a miss with the table full, the entry at alloc_ptr is evicted silently (FIFO replacement).
- LOAD: load_state=1 for exactly one cycle; s_ready=0.
- WAIT: one cycle, s_ready=0. The first char_in_vld is therefore at least 2 cycles after load_state.
- After WAIT: go to STREAM, or to DRAIN if short flag set or the packet ended with the last key byte.
- STREAM:
  - s_ready=1; char_in <= s_data and char_in_vld <= s_valid, both registered with 1-cycle latency.
  - Beat with s_eop is forwarded, then go to DRAIN.
  - s_valid gaps produce char_in_vld=0 cycles; no timeout.
- DRAIN: EOP_GAP cycles with char_in_vld=0 and s_ready=0, then FIN.
- FIN: eop=1 for one cycle, then IDLE. stream_id and new_stream_id hold until the next LOOKUP.
- Ordering guarantees:
  - Exactly one load_state and one eop per accepted packet, in that order.
  - Never char_in_vld together with load_state or eop.
- Zero-payload packets still produce load_state, then eop (load_state->eop spacing >= 2+EOP_GAP), so fingers save the unchanged state.
- flush arriving mid-packet is ignored until IDLE; a level still high in IDLE is honoured.
- s_ready is a registered function of state only; there is no combinational path from s_valid.

Decomposition:
- Shared package dpi_pkg: state enum; SID_W/NUM_STREAMS constants; key width function KEY_W=8*KEY_BYTES.
- One sub-module: dpi_flow_table. It holds the valid/key arrays and alloc_ptr, performs the 1-cycle lookup, and provides allocate and flush ports.
- The FSM and byte path stay in the top level.

Test Plan:
- Reset, then packet sop key 0x0A0B0C0D + payload "abc" -> load_state; new_stream_id=1, stream_id=0; chars 'a','b','c' starting >=2 cycles after load_state; eop 3 cycles after 'c' (EOP_GAP=2).
- Same key again -> stream_id=0, new_stream_id=0; a different key -> stream_id=1, new_stream_id=1.
- 65 distinct keys -> IDs 0..63, the 65th gets ID 0; reissuing the first key then misses and gets ID 1.
- 2-byte packet with s_sop&s_eop on byte 1 -> key 0xXXYY0000, no char_in_vld, load_state followed by eop exactly 4 cycles later.
- s_valid toggling 1/0 during payload, plus non-sop beats in IDLE -> chars forwarded in order with gaps; IDLE beats dropped with no load_state.
- flush asserted mid-packet -> current packet completes normally; the table clears in IDLE; the previous key then misses with stream_id=0.

Source files
------------

// File: rtl/dpi_pkg.sv
// Shared definitions for the DPI stream sequencer: FSM states, table sizing and key width.
package dpi_pkg;

    localparam int unsigned DPI_SID_W       = 6;
    localparam int unsigned DPI_NUM_STREAMS = 1 << DPI_SID_W;

    typedef enum logic [2:0] {
        StIdle,
        StKey,
        StLookup,
        StLoad,
        StWait,
        StStream,
        StDrain,
        StFin
    } dpi_state_e;

    function automatic int unsigned key_w(input int unsigned key_bytes);
        return 8 * key_bytes;
    endfunction

endpackage

// File: rtl/dpi_flow_table.sv
// Fully-associative flow table: combinational key match, FIFO-order allocation, bulk flush.
module dpi_flow_table
    import dpi_pkg::*;
#(
    parameter int unsigned NUM_STREAMS = DPI_NUM_STREAMS,
    parameter int unsigned SID_W       = DPI_SID_W,
    parameter int unsigned KEY_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc,
    input  logic [KEY_W-1:0] key,
    output logic             hit,
    output logic [SID_W-1:0] hit_idx,
    output logic [SID_W-1:0] alloc_ptr
);

    logic [NUM_STREAMS-1:0] valid_q;
    logic [KEY_W-1:0]       key_q [NUM_STREAMS];
    logic [SID_W-1:0]       ptr_q;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (valid_q[i] && (key_q[i] == key)) begin
                hit     = 1'b1;
                hit_idx = SID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (alloc) begin
            valid_q[ptr_q] <= 1'b1;
            ptr_q          <= ptr_q + 1'b1;
        end
    end

    // Key storage needs no reset; an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc && !flush) begin
            key_q[ptr_q] <= key;
        end
    end

    assign alloc_ptr = ptr_q;

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Packet front end: extracts the flow key, resolves a stream ID and sequences
// load_state / payload chars / eop towards the finger array.
module dpi_stream_sequencer
    import dpi_pkg::*;
#(
    parameter int unsigned NUM_STREAMS = DPI_NUM_STREAMS,
    parameter int unsigned SID_W       = DPI_SID_W,
    parameter int unsigned KEY_BYTES   = 4,
    parameter int unsigned EOP_GAP     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_sop,
    input  logic             s_eop,
    output logic             s_ready,
    input  logic             flush,
    output logic [7:0]       char_in,
    output logic             char_in_vld,
    output logic             load_state,
    output logic [SID_W-1:0] stream_id,
    output logic             new_stream_id,
    output logic             eop,
    output logic             busy
);

    localparam int unsigned KEY_W   = key_w(KEY_BYTES);
    localparam int          KB      = int'(KEY_BYTES);
    localparam int unsigned CNT_MAX = (KEY_BYTES > EOP_GAP) ? KEY_BYTES : EOP_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    dpi_state_e       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_eop_q, key_eop_d;
    logic [SID_W-1:0] sid_q, sid_d;
    logic             new_q, new_d;
    logic [7:0]       char_q, char_d;
    logic             char_vld_q, char_vld_d;

    logic             tbl_hit;
    logic [SID_W-1:0] tbl_hit_idx;
    logic [SID_W-1:0] tbl_alloc_ptr;
    logic             tbl_flush;
    logic             tbl_alloc;

    assign tbl_flush = (state_q == StIdle) && flush;
    assign tbl_alloc = (state_q == StLookup) && !tbl_hit;

    dpi_flow_table #(
        .NUM_STREAMS (NUM_STREAMS),
        .SID_W       (SID_W),
        .KEY_W       (KEY_W)
    ) u_flow_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (tbl_flush),
        .alloc     (tbl_alloc),
        .key       (key_q),
        .hit       (tbl_hit),
        .hit_idx   (tbl_hit_idx),
        .alloc_ptr (tbl_alloc_ptr)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        key_eop_d  = key_eop_q;
        sid_d      = sid_q;
        new_d      = new_q;
        char_d     = char_q;
        char_vld_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!flush && s_valid && s_sop) begin
                    key_d                 = '0;
                    key_d[KEY_W-1 -: 8]   = s_data;
                    cnt_d                 = CNT_W'(1);
                    key_eop_d             = s_eop;
                    state_d               = (s_eop || KB == 1) ? StLookup : StKey;
                end
            end
            StKey: begin
                if (s_valid) begin
                    for (int i = 1; i < KB; i++) begin
                        if (int'(cnt_q) == i) key_d[8*(KB-i)-1 -: 8] = s_data;
                    end
                    cnt_d     = cnt_q + 1'b1;
                    key_eop_d = s_eop;
                    if (s_eop || int'(cnt_q) == KB - 1) state_d = StLookup;
                end
            end
            StLookup: begin
                sid_d   = tbl_hit ? tbl_hit_idx : tbl_alloc_ptr;
                new_d   = !tbl_hit;
                state_d = StLoad;
            end
            StLoad: state_d = StWait;
            StWait: begin
                if (key_eop_q) begin
                    state_d = StDrain;
                    cnt_d   = CNT_W'(EOP_GAP - 1);
                end else begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (s_valid) begin
                    char_d     = s_data;
                    char_vld_d = 1'b1;
                    // One extra drain cycle covers the registered last char still in flight.
                    if (s_eop) begin
                        state_d = StDrain;
                        cnt_d   = CNT_W'(EOP_GAP);
                    end
                end
            end
            StDrain: begin
                if (cnt_q == '0) state_d = StFin;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            key_q      <= '0;
            cnt_q      <= '0;
            key_eop_q  <= 1'b0;
            sid_q      <= '0;
            new_q      <= 1'b0;
            char_q     <= '0;
            char_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            key_eop_q  <= key_eop_d;
            sid_q      <= sid_d;
            new_q      <= new_d;
            char_q     <= char_d;
            char_vld_q <= char_vld_d;
        end
    end

    assign s_ready       = (state_q == StIdle) || (state_q == StKey) || (state_q == StStream);
    assign busy          = (state_q != StIdle);
    assign load_state    = (state_q == StLoad);
    assign eop           = (state_q == StFin);
    assign char_in       = char_q;
    assign char_in_vld   = char_vld_q;
    assign stream_id     = sid_q;
    assign new_stream_id = new_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Scoreboard bench: packet stimulus queues expected load/char/eop events, a monitor checks them.
module tb_dpi_stream_sequencer;

    localparam int EOP_GAP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_sop = 1'b0;
    logic       s_eop = 1'b0;
    logic       flush = 1'b0;
    logic       s_ready;
    logic [7:0] char_in;
    logic       char_in_vld;
    logic       load_state;
    logic [5:0] stream_id;
    logic       new_stream_id;
    logic       eop;
    logic       busy;

    dpi_stream_sequencer #(
        .NUM_STREAMS (64),
        .SID_W       (6),
        .KEY_BYTES   (4),
        .EOP_GAP     (EOP_GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_sop         (s_sop),
        .s_eop         (s_eop),
        .s_ready       (s_ready),
        .flush         (flush),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .load_state    (load_state),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .eop           (eop),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EvLoad, EvChar, EvEop} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
        logic [5:0] sid;
        logic       nw;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_tests = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    int  load_cyc = 0;
    int  char_cyc = 0;
    int  nchars = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en && (load_state || eop || char_in_vld)) begin
            if (load_state || eop) check("no_char_with_pulse", char_in_vld, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                if (load_state) begin
                    check("load_kind", int'(mon_e.kind), int'(EvLoad));
                    check("load_sid", stream_id, mon_e.sid);
                    check("load_new", new_stream_id, mon_e.nw);
                    check("busy_at_load", busy, 1);
                    load_cyc = cyc;
                    nchars   = 0;
                end else if (eop) begin
                    check("eop_kind", int'(mon_e.kind), int'(EvEop));
                    check("eop_sid", stream_id, mon_e.sid);
                    check("eop_new", new_stream_id, mon_e.nw);
                    if (nchars == 0) check("eop_after_load", cyc - load_cyc, 2 + EOP_GAP);
                    else             check("eop_after_last_char", cyc - char_cyc, EOP_GAP + 1);
                end else begin
                    check("char_kind", int'(mon_e.kind), int'(EvChar));
                    check("char_data", char_in, mon_e.data);
                    if (nchars == 0) check("load_to_char_gap_ge2", (cyc - load_cyc) >= 2, 1);
                    char_cyc = cyc;
                    nchars++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit sop, input bit last);
        int guard = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_sop   = sop;
        s_eop   = last;
        @(negedge clk);
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL s_ready_timeout: got s_ready=0 for 200 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1 for 200 cycles, expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic packet(input logic [31:0] key, input int nkey, input string pay,
                          input logic [5:0] sid, input bit nw, input bit gaps,
                          input bit flush_mid);
        ev_t e;
        e.kind = EvLoad;
        e.data = '0;
        e.sid  = sid;
        e.nw   = nw;
        exp_q.push_back(e);
        for (int i = 0; i < pay.len(); i++) begin
            e.kind = EvChar;
            e.data = pay[i];
            exp_q.push_back(e);
        end
        e.kind = EvEop;
        e.data = '0;
        exp_q.push_back(e);
        for (int i = 0; i < nkey; i++) begin
            send(key[31-8*i -: 8], i == 0, (i == nkey - 1) && (pay.len() == 0));
        end
        if (flush_mid) flush = 1'b1;
        for (int i = 0; i < pay.len(); i++) begin
            send(pay[i], 1'b0, i == pay.len() - 1);
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_load_state", load_state, 0);
        check("rst_eop", eop, 0);
        check("rst_char_in_vld", char_in_vld, 0);
        check("rst_char_in", char_in, 0);
        check("rst_stream_id", stream_id, 0);
        check("rst_new_stream_id", new_stream_id, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        packet(32'h0A0B0C0D, 4, "abc", 6'd0, 1'b1, 1'b0, 1'b0);
        packet(32'h0A0B0C0D, 4, "x", 6'd0, 1'b0, 1'b0, 1'b0);
        // Non-sop beats in IDLE are dropped and must raise nothing.
        send(8'h99, 1'b0, 1'b0);
        send(8'h98, 1'b0, 1'b1);
        packet(32'h11223344, 4, "yz!", 6'd1, 1'b1, 1'b1, 1'b0);
        packet(32'h55660000, 2, "", 6'd2, 1'b1, 1'b0, 1'b0);

        // Flush raised mid-packet: the packet completes, the table clears once idle.
        packet(32'h0A0B0C0D, 4, "pq", 6'd0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        repeat (2) @(posedge clk);
        #1 flush = 1'b0;
        packet(32'h0A0B0C0D, 4, "r", 6'd0, 1'b1, 1'b0, 1'b0);

        wait_idle();
        flush = 1'b1;
        repeat (2) @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < 65; i++) begin
            packet(32'hC0DE0000 + 32'(i), 4, "", 6'(i % 64), 1'b1, 1'b0, 1'b0);
        end
        packet(32'hC0DE0000, 4, "", 6'd1, 1'b1, 1'b0, 1'b0);
        packet(32'hC0DE0005, 4, "k", 6'd5, 1'b0, 1'b0, 1'b0);

        wait_idle();
        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no completion, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
